// File: rtl/draw_polyline.sv
// draw_polyline: walks a vertex list held in a synchronous buffer and feeds
// draw_line one segment at a time (N-1 segments, or N with the closing edge).
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   plot              start request, acted on at its rising edge while idle
//   busy              high from the cycle after start until the run ends
//   len               vertex count N, sampled at start (N < 2 is ignored)
//   color             RGB565 segment color, sampled at start
//   addr / data       buffer port: x of vertex i at 2i, y at 2i+1; data is
//                     valid one cycle after addr
//   line_plot         one-cycle request pulse to draw_line
//   line_busy         draw_line busy
//   line_x0..line_y1  segment endpoints, held from line_plot until done
//   line_color        color latched at start
//   state_dbg         current FSM state encoding
//
// Handshake: a rising plot edge in IDLE with len >= 2 starts a run and busy
// stays high until the last segment completes; edges while busy are dropped.
// Each segment is offered with a single-cycle line_plot, then line_busy must
// rise within c_ack_wait cycles (otherwise the segment is taken as done) and
// the segment is complete once line_busy falls again.
module draw_polyline #(
  parameter int c_addr_bits = 9,
  parameter bit c_closed    = 1'b0,
  parameter int c_ack_wait  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   plot,
  output logic                   busy,
  input  logic [c_addr_bits-1:0] len,
  input  logic [15:0]            color,
  output logic [c_addr_bits-1:0] addr,
  input  logic [15:0]            data,
  output logic                   line_plot,
  input  logic                   line_busy,
  output logic [15:0]            line_x0,
  output logic [15:0]            line_y0,
  output logic [15:0]            line_x1,
  output logic [15:0]            line_y1,
  output logic [15:0]            line_color,
  output logic [3:0]             state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RD_X0     = 4'd1,
    S_RD_Y0     = 4'd2,
    S_RD_X1     = 4'd3,
    S_RD_Y1     = 4'd4,
    S_REQ       = 4'd5,
    S_ACK       = 4'd6,
    S_DONE_WAIT = 4'd7,
    S_NEXT      = 4'd8
  } state_t;

  localparam int c_cnt_bits = $clog2(c_ack_wait + 1);

  state_t                 state_q, state_d;
  logic                   phase_q;          // 0: addr presented, 1: data valid
  logic                   plot_d;
  logic [c_addr_bits-1:0] len_q;
  logic [c_addr_bits-1:0] idx_q;
  logic [15:0]            v0x_q, v0y_q;     // vertex 0 kept for the closing edge
  logic                   closing_done_q;
  logic [c_cnt_bits-1:0]  ack_cnt_q;

  logic                   start;
  logic [c_addr_bits:0]   idx_plus2;
  logic                   more_reads;
  logic [c_addr_bits-1:0] next_vtx_addr;

  assign start     = (state_q == S_IDLE) && plot && !plot_d
                     && (len >= c_addr_bits'(2));
  // In NEXT the index is about to become idx+1; the vertex still to read is idx+2.
  assign idx_plus2  = {1'b0, idx_q} + (c_addr_bits + 1)'(2);
  assign more_reads = idx_plus2 < {1'b0, len_q};
  assign next_vtx_addr = {idx_plus2[c_addr_bits-2:0], 1'b0};

  assign busy      = (state_q != S_IDLE);
  assign line_plot = (state_q == S_REQ);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_RD_X0;
      S_RD_X0:     if (phase_q) state_d = S_RD_Y0;
      S_RD_Y0:     if (phase_q) state_d = S_RD_X1;
      S_RD_X1:     if (phase_q) state_d = S_RD_Y1;
      S_RD_Y1:     if (phase_q) state_d = S_REQ;
      S_REQ:       state_d = S_ACK;
      S_ACK: begin
        if (line_busy)
          state_d = S_DONE_WAIT;
        else if (ack_cnt_q == c_cnt_bits'(c_ack_wait - 1))
          state_d = S_NEXT;
      end
      S_DONE_WAIT: if (!line_busy) state_d = S_NEXT;
      S_NEXT: begin
        if (more_reads)
          state_d = S_RD_X1;
        else if (c_closed && !closing_done_q)
          state_d = S_REQ;
        else
          state_d = S_IDLE;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      phase_q        <= 1'b0;
      plot_d         <= 1'b0;
      len_q          <= '0;
      idx_q          <= '0;
      v0x_q          <= '0;
      v0y_q          <= '0;
      closing_done_q <= 1'b0;
      ack_cnt_q      <= '0;
      addr           <= '0;
      line_x0        <= '0;
      line_y0        <= '0;
      line_x1        <= '0;
      line_y1        <= '0;
      line_color     <= '0;
    end else begin
      state_q   <= state_d;
      plot_d    <= plot;
      // Every read state lasts exactly two cycles; phase restarts on entry.
      phase_q   <= (state_d == state_q) ? ~phase_q : 1'b0;
      ack_cnt_q <= (state_q == S_ACK) ? ack_cnt_q + 1'b1 : '0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q          <= len;
            line_color     <= color;
            idx_q          <= '0;
            closing_done_q <= 1'b0;
            addr           <= '0;
          end
        end
        S_RD_X0: if (phase_q) begin
          line_x0 <= data;
          v0x_q   <= data;
          addr    <= addr + 1'b1;
        end
        S_RD_Y0: if (phase_q) begin
          line_y0 <= data;
          v0y_q   <= data;
          addr    <= addr + 1'b1;
        end
        S_RD_X1: if (phase_q) begin
          line_x1 <= data;
          addr    <= addr + 1'b1;
        end
        S_RD_Y1: if (phase_q) line_y1 <= data;
        S_NEXT: begin
          line_x0 <= line_x1;
          line_y0 <= line_y1;
          idx_q   <= idx_q + 1'b1;
          if (more_reads) begin
            addr <= next_vtx_addr;
          end else if (c_closed && !closing_done_q) begin
            line_x1        <= v0x_q;
            line_y1        <= v0y_q;
            closing_done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_polyline.sv
// Bench for draw_polyline: an open (c_closed=0) and a closed (c_closed=1)
// instance share clock, reset and start inputs; each has its own buffer port
// and draw_line model. Expected segments are queued by the driver and popped
// by a monitor whenever line_plot is seen.
module tb_draw_polyline;

  logic        clk = 1'b0;
  logic        reset;
  logic        plot;
  logic [8:0]  len;
  logic [15:0] color;
  logic        dl_mode;   // 0: draw_line busy for 5 cycles, 1: line_busy tied 0

  logic        busy_o, busy_c;
  logic [8:0]  addr_o, addr_c;
  logic [15:0] data_o, data_c;
  logic        line_plot_o, line_plot_c;
  logic        line_busy_o, line_busy_c;
  logic [15:0] x0_o, y0_o, x1_o, y1_o, col_o;
  logic [15:0] x0_c, y0_c, x1_c, y1_c, col_c;
  logic [3:0]  state_dbg_o, state_dbg_c;

  logic [15:0] mem [0:511];
  logic [2:0]  bcnt_o, bcnt_c;

  logic [79:0] exp_o[$];
  logic [79:0] exp_c[$];
  logic [79:0] held_o, held_c;
  int          pulses_o = 0, pulses_c = 0;
  int          n_checks = 0, n_pass = 0;

  draw_polyline #(.c_addr_bits(9), .c_closed(1'b0), .c_ack_wait(4)) dut_o (
    .clk(clk), .reset(reset), .plot(plot), .busy(busy_o), .len(len),
    .color(color), .addr(addr_o), .data(data_o), .line_plot(line_plot_o),
    .line_busy(line_busy_o), .line_x0(x0_o), .line_y0(y0_o), .line_x1(x1_o),
    .line_y1(y1_o), .line_color(col_o), .state_dbg(state_dbg_o)
  );

  draw_polyline #(.c_addr_bits(9), .c_closed(1'b1), .c_ack_wait(4)) dut_c (
    .clk(clk), .reset(reset), .plot(plot), .busy(busy_c), .len(len),
    .color(color), .addr(addr_c), .data(data_c), .line_plot(line_plot_c),
    .line_busy(line_busy_c), .line_x0(x0_c), .line_y0(y0_c), .line_x1(x1_c),
    .line_y1(y1_c), .line_color(col_c), .state_dbg(state_dbg_c)
  );

  // ---------------- clock / reset-independent models ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    data_o <= mem[addr_o];
    data_c <= mem[addr_c];
  end

  always @(posedge clk) begin
    if (reset) begin
      bcnt_o <= 3'd0;
      bcnt_c <= 3'd0;
    end else begin
      if (line_plot_o) bcnt_o <= 3'd5;
      else if (bcnt_o != 3'd0) bcnt_o <= bcnt_o - 3'd1;
      if (line_plot_c) bcnt_c <= 3'd5;
      else if (bcnt_c != 3'd0) bcnt_c <= bcnt_c - 3'd1;
    end
  end

  assign line_busy_o = !dl_mode && (bcnt_o != 3'd0);
  assign line_busy_c = !dl_mode && (bcnt_c != 3'd0);

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic checki(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (line_plot_o) begin
        pulses_o++;
        held_o = {x0_o, y0_o, x1_o, y1_o, col_o};
        if (exp_o.size() == 0) begin
          n_checks++;
          $display("FAIL seg_o_extra: got segment %h expected none", held_o);
        end else begin
          check("seg_o", held_o, exp_o.pop_front());
        end
      end else if (line_busy_o) begin
        check("hold_o", {x0_o, y0_o, x1_o, y1_o, col_o}, held_o);
      end
      if (line_plot_c) begin
        pulses_c++;
        held_c = {x0_c, y0_c, x1_c, y1_c, col_c};
        if (exp_c.size() == 0) begin
          n_checks++;
          $display("FAIL seg_c_extra: got segment %h expected none", held_c);
        end else begin
          check("seg_c", held_c, exp_c.pop_front());
        end
      end else if (line_busy_c) begin
        check("hold_c", {x0_c, y0_c, x1_c, y1_c, col_c}, held_c);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Buffer holds (10,20),(100,20),(100,200).
  task automatic push_tri(input logic [15:0] c);
    exp_o.push_back({16'd10, 16'd20, 16'd100, 16'd20, c});
    exp_o.push_back({16'd100, 16'd20, 16'd100, 16'd200, c});
    exp_c.push_back({16'd10, 16'd20, 16'd100, 16'd20, c});
    exp_c.push_back({16'd100, 16'd20, 16'd100, 16'd200, c});
    exp_c.push_back({16'd100, 16'd200, 16'd10, 16'd20, c});
  endtask

  task automatic start_plot(input logic [8:0] n, input logic [15:0] c);
    @(negedge clk);
    len   = n;
    color = c;
    plot  = 1'b1;
  endtask

  // Number of negedges from raising plot to the first line_plot, -1 on timeout.
  task automatic wait_first_pulse(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (line_plot_o) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      if (!busy_o && !busy_c) break;
      @(negedge clk);
    end
    check(name, 80'({busy_o, busy_c}), 80'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl_o"}, 80'({busy_o, line_plot_o, addr_o}), 80'd0);
    check({tag, "_line_o"}, {x0_o, y0_o, x1_o, y1_o, col_o}, 80'd0);
    check({tag, "_ctl_c"}, 80'({busy_c, line_plot_c, addr_c}), 80'd0);
    check({tag, "_line_c"}, {x0_c, y0_c, x1_c, y1_c, col_c}, 80'd0);
  endtask

  task automatic check_run(input string tag, input int p0o, input int p0c);
    checki({tag, "_pulses_o"}, pulses_o - p0o, 2);
    checki({tag, "_pulses_c"}, pulses_c - p0c, 3);
    checki({tag, "_q_o"}, exp_o.size(), 0);
    checki({tag, "_q_c"}, exp_c.size(), 0);
    checki({tag, "_addr_o"}, int'(addr_o), 5);
    checki({tag, "_addr_c"}, int'(addr_c), 5);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int k, p0o, p0c, first, second, a0o, a0c;
    bit saw;

    reset   = 1'b1;
    plot    = 1'b0;
    len     = '0;
    color   = '0;
    dl_mode = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0] = 16'd10;  mem[1] = 16'd20;
    mem[2] = 16'd100; mem[3] = 16'd20;
    mem[4] = 16'd100; mem[5] = 16'd200;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Open/closed triangle; vertex 0 is corrupted after the first segment so
    // the closing edge only matches if vertex 0 was kept internally.
    p0o = pulses_o; p0c = pulses_c;
    push_tri(16'hF800);
    start_plot(9'd3, 16'hF800);
    wait_first_pulse(k);
    plot = 1'b0;
    checki("latency_t1", k, 9);
    mem[0] = 16'h0999; mem[1] = 16'h0888;
    wait_idle("idle_t1");
    check_run("t1", p0o, p0c);
    mem[0] = 16'd10; mem[1] = 16'd20;

    // len 0 and 1 are ignored.
    for (int n = 0; n < 2; n++) begin
      a0o = int'(addr_o); a0c = int'(addr_c);
      saw = 1'b0;
      start_plot(9'(n), 16'h1111);
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (busy_o || busy_c || line_plot_o || line_plot_c) saw = 1'b1;
        if (i == 3) plot = 1'b0;
      end
      checki($sformatf("short_len%0d_active", n), int'(saw), 0);
      checki($sformatf("short_len%0d_addr_o", n), int'(addr_o), a0o);
      checki($sformatf("short_len%0d_addr_c", n), int'(addr_c), a0c);
    end

    // Extra plot edges while busy must not queue another run.
    p0o = pulses_o; p0c = pulses_c;
    push_tri(16'h07E0);
    start_plot(9'd3, 16'h07E0);
    wait_first_pulse(k);
    checki("latency_t3", k, 9);
    repeat (3) @(negedge clk);
    plot = 1'b0;
    repeat (2) @(negedge clk);
    plot = 1'b1;
    repeat (2) @(negedge clk);
    plot = 1'b0;
    wait_idle("idle_t3");
    repeat (20) @(negedge clk);
    check_run("t3", p0o, p0c);

    // line_busy never answers: each segment times out after the ack window.
    dl_mode = 1'b1;
    p0o = pulses_o; p0c = pulses_c;
    push_tri(16'h001F);
    start_plot(9'd3, 16'h001F);
    first = -1; second = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 2) plot = 1'b0;
      if (line_plot_o) begin
        if (first < 0) first = i;
        else second = i;
      end
      if (i > 2 && !busy_o && !busy_c) break;
    end
    checki("latency_t4", first, 9);
    checki("spacing_t4", second - first, 10);
    wait_idle("idle_t4");
    check_run("t4", p0o, p0c);
    dl_mode = 1'b0;

    // Reset in the middle of segment 1, then a clean rerun.
    push_tri(16'hFFFF);
    start_plot(9'd3, 16'hFFFF);
    wait_first_pulse(k);
    plot = 1'b0;
    repeat (2) @(negedge clk);
    checki("done_wait_o", int'(state_dbg_o), 7);
    reset = 1'b1;
    exp_o.delete();
    exp_c.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checki("midrst_no_pulse", int'({line_plot_o, line_plot_c, busy_o, busy_c}), 0);

    p0o = pulses_o; p0c = pulses_c;
    push_tri(16'h1234);
    start_plot(9'd3, 16'h1234);
    wait_first_pulse(k);
    plot = 1'b0;
    checki("latency_t5", k, 9);
    wait_idle("idle_t5");
    check_run("t5", p0o, p0c);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
